// File: rtl/game_pkg.sv
// game_pkg: shared move/cooldown types and direction-resolution helper for player input conditioning
//   MOVE_UP..MOVE_RIGHT : bit indices within a move_t
//   move_t              : 4-bit direction vector
//   cooldown_t          : 8-bit frame cooldown count
//   resolve_move()      : cancels contradictory up/down and left/right pairs
package game_pkg;

    localparam int MOVE_BITS  = 4;
    localparam int MOVE_UP    = 0;
    localparam int MOVE_DOWN  = 1;
    localparam int MOVE_LEFT  = 2;
    localparam int MOVE_RIGHT = 3;

    typedef logic [MOVE_BITS-1:0] move_t;
    typedef logic [7:0]           cooldown_t;

    function automatic move_t resolve_move(move_t m);
        resolve_move = {m[MOVE_RIGHT] & ~m[MOVE_LEFT], m[MOVE_LEFT] & ~m[MOVE_RIGHT],
                        m[MOVE_DOWN] & ~m[MOVE_UP], m[MOVE_UP] & ~m[MOVE_DOWN]};
    endfunction

endpackage

// File: rtl/player_input_ctrl_if.sv
// player_input_ctrl_if: bundle between raw board inputs / game logic and player_input_ctrl
//   move_i, shoot_i          : raw, asynchronous controller lines
//   frame_start_i            : one-cycle pulse per video frame
//   game_enable_i            : game running; low ignores inputs
//   move_o, shoot_o          : frame-latched directions, one-cycle shot commands
//   cooldown_o               : remaining cooldown frames per player
//   master drives the raw inputs, slave (player_input_ctrl) drives the outputs
interface player_input_ctrl_if #(parameter int NUM_PLAYERS = 2);
    import game_pkg::*;

    move_t     [NUM_PLAYERS-1:0] move_i;
    logic      [NUM_PLAYERS-1:0] shoot_i;
    logic                        frame_start_i;
    logic                        game_enable_i;
    move_t     [NUM_PLAYERS-1:0] move_o;
    logic      [NUM_PLAYERS-1:0] shoot_o;
    cooldown_t [NUM_PLAYERS-1:0] cooldown_o;

    modport master (
        output move_i, shoot_i, frame_start_i, game_enable_i,
        input  move_o, shoot_o, cooldown_o
    );

    modport slave (
        input  move_i, shoot_i, frame_start_i, game_enable_i,
        output move_o, shoot_o, cooldown_o
    );

endinterface

// File: rtl/input_debounce.sv
// input_debounce: 2-flop synchroniser plus per-bit debouncer
//   clk_i   : system clock
//   reset_i : asynchronous active-low reset
//   raw_i   : asynchronous raw lines
//   level_o : debounced level; follows raw_i after it is stable for DEBOUNCE_CYCLES synced cycles
module input_debounce #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] level_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0]         sync1, sync2;
    logic [WIDTH-1:0][CW-1:0] cnt;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync1   <= '0;
            sync2   <= '0;
            level_o <= '0;
            cnt     <= '0;
        end else begin
            sync1 <= raw_i;
            sync2 <= sync1;
            // counter tracks consecutive cycles the synced value disagrees with the accepted level
            for (int b = 0; b < WIDTH; b++) begin
                if (sync2[b] == level_o[b])
                    cnt[b] <= '0;
                else if (cnt[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level_o[b] <= sync2[b];
                    cnt[b]     <= '0;
                end else
                    cnt[b] <= cnt[b] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_input_ctrl.sv
// player_input_ctrl: N-player input conditioner (debounce, direction resolution, frame-latched moves, rate-limited shots)
//   clk_i   : system/pixel clock
//   reset_i : asynchronous active-low reset
//   bus     : player_input_ctrl_if.slave (raw inputs in, move_o/shoot_o/cooldown_o out)
//   PLAYER_INPUT_AUTOFIRE_EN : when defined, a held fire button keeps a shot pending (autofire)
module player_input_ctrl
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int MOVE_BITS       = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COOLDOWN_FRAMES = 3
) (
    input logic                  clk_i,
    input logic                  reset_i,
    player_input_ctrl_if.slave   bus
);

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        move_t     move_db, move_q;
        logic      shoot_db, shoot_q, pending, set_pend, fire;
        cooldown_t cooldown;

        input_debounce #(.WIDTH(MOVE_BITS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_move (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .raw_i   (bus.move_i[p]),
            .level_o (move_db)
        );

        input_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_shoot (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .raw_i   (bus.shoot_i[p]),
            .level_o (shoot_db)
        );

`ifdef PLAYER_INPUT_AUTOFIRE_EN
        assign set_pend = shoot_db;
`else
        logic shoot_prev;
        always_ff @(posedge clk_i or negedge reset_i)
            if (!reset_i) shoot_prev <= 1'b0;
            else          shoot_prev <= shoot_db;
        assign set_pend = shoot_db & ~shoot_prev;
`endif

        assign fire = bus.frame_start_i & bus.game_enable_i & pending & (cooldown == '0);

        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                pending  <= 1'b0;
                shoot_q  <= 1'b0;
                move_q   <= '0;
                cooldown <= '0;
            end else begin
                // a new press in the firing cycle stays buffered for the next eligible frame
                pending <= bus.game_enable_i & (set_pend | (pending & ~fire));
                shoot_q <= fire;
                if (bus.frame_start_i) begin
                    move_q   <= bus.game_enable_i ? resolve_move(move_db) : '0;
                    cooldown <= fire ? cooldown_t'(COOLDOWN_FRAMES) :
                                (cooldown != '0) ? cooldown - 1'b1 : cooldown;
                end
            end
        end

        assign bus.move_o[p]     = move_q;
        assign bus.shoot_o[p]    = shoot_q;
        assign bus.cooldown_o[p] = cooldown;
    end

endmodule

// File: tb/tb_player_input_ctrl.sv
// tb_player_input_ctrl: directed self-checking bench for player_input_ctrl (2 players, debounce 4, cooldown 3)
module tb_player_input_ctrl;
    import game_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   fails = 0;
    int   shots;

    always #5 clk = ~clk;

    player_input_ctrl_if #(.NUM_PLAYERS(2)) bus ();

    player_input_ctrl #(
        .NUM_PLAYERS     (2),
        .MOVE_BITS       (4),
        .DEBOUNCE_CYCLES (4),
        .COOLDOWN_FRAMES (3)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.frame_start_i = 1'b1;
        cycles(1);
        bus.frame_start_i = 1'b0;
    endtask

    task automatic frame_after(input int n);
        cycles(n);
        frame();
    endtask

    task automatic press(input int p);
        bus.shoot_i[p] = 1'b1;
        cycles(10);
        bus.shoot_i[p] = 1'b0;
    endtask

    initial begin
        bus.move_i        = '0;
        bus.shoot_i       = '0;
        bus.frame_start_i = 1'b0;
        bus.game_enable_i = 1'b1;
        cycles(3);
        check("rst_move", bus.move_o, 0);
        check("rst_shoot", bus.shoot_o, 0);
        check("rst_cd", bus.cooldown_o, 0);
        reset_n = 1'b1;
        cycles(2);

        // 2-cycle glitches never reach the debounced level
        repeat (3) begin
            bus.move_i[0] = 4'b0001;
            cycles(2);
            bus.move_i[0] = 4'b0000;
            cycles(2);
        end
        frame_after(10);
        check("glitch_move", bus.move_o[0], 0);

        // debounced level lands exactly 6 cycles after the raw edge
        bus.move_i[0] = 4'b0001;
        frame_after(5);
        check("deb_early", bus.move_o[0], 0);
        frame();
        check("deb_move", bus.move_o[0], 4'b0001);
        check("deb_p1_idle", bus.move_o[1], 0);

        bus.move_i[0] = 4'b1111;
        frame_after(10);
        check("resolve_all", bus.move_o[0], 4'b0000);
        bus.move_i[0] = 4'b0101;
        bus.move_i[1] = 4'b1010;
        frame_after(10);
        check("resolve_0101", bus.move_o[0], 4'b0101);
        check("resolve_1010", bus.move_o[1], 4'b1010);
        bus.move_i = '0;
        cycles(10);
        check("move_held", bus.move_o[0], 4'b0101);
        frame();
        check("move_clear", bus.move_o, 0);

        // single shot, cooldown 3,2,1,0, re-press fires 4 frames after the first shot
        press(0);
        frame_after(89);
        check("shot1", bus.shoot_o[0], 1);
        check("shot1_cd", bus.cooldown_o[0], 3);
        cycles(1);
        check("shot1_pulse", bus.shoot_o[0], 0);
        frame_after(98);
        check("cd2", bus.cooldown_o[0], 2);
        check("cd2_noshot", bus.shoot_o[0], 0);
        press(0);
        frame_after(89);
        check("cd1", bus.cooldown_o[0], 1);
        check("cd1_noshot", bus.shoot_o[0], 0);
        frame_after(99);
        check("cd0", bus.cooldown_o[0], 0);
        check("cd0_noshot", bus.shoot_o[0], 0);
        frame_after(99);
        check("shot2", bus.shoot_o[0], 1);
        check("shot2_cd", bus.cooldown_o[0], 3);

        // hold player 1 fire for 10 frames
        bus.shoot_i[1] = 1'b1;
        cycles(10);
        shots = 0;
        repeat (10) begin
            frame_after(99);
            shots += int'(bus.shoot_o[1]);
        end
        bus.shoot_i[1] = 1'b0;
`ifdef PLAYER_INPUT_AUTOFIRE_EN
        check("hold_shots", shots, 3);
`else
        check("hold_shots", shots, 1);
`endif

        // reset mid-stream clears outputs at once and until the first frame after release
        bus.move_i[0] = 4'b0001;
        press(0);
        frame_after(89);
        check("pre_rst_shot", bus.shoot_o[0], 1);
        check("pre_rst_cd", bus.cooldown_o[0], 3);
        cycles(20);
        reset_n = 1'b0;
        #2;
        check("async_rst_move", bus.move_o, 0);
        check("async_rst_cd", bus.cooldown_o, 0);
        check("async_rst_shoot", bus.shoot_o, 0);
        cycles(3);
        reset_n = 1'b1;
        cycles(20);
        check("post_rst_move", bus.move_o, 0);
        frame();
        check("post_rst_frame_move", bus.move_o[0], 4'b0001);
        check("post_rst_noshot", bus.shoot_o, 0);
        check("post_rst_cd", bus.cooldown_o, 0);

        // disabled game ignores presses and issues no stale shot on re-enable
        bus.game_enable_i = 1'b0;
        bus.shoot_i[0] = 1'b1;
        frame_after(10);
        check("dis_shoot", bus.shoot_o[0], 0);
        check("dis_move", bus.move_o[0], 0);
        bus.shoot_i[0] = 1'b0;
        cycles(10);
        bus.game_enable_i = 1'b1;
        frame();
        check("en_noshot", bus.shoot_o[0], 0);
        check("en_move", bus.move_o[0], 4'b0001);
        frame_after(99);
        check("en_noshot2", bus.shoot_o[0], 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
